// File: rtl/uart_mem_xfer.sv
// Block transfer engine between a UART link and a word-wide synchronous memory.
// Includes the 8N1 uart_tx / uart_rx cores it drives.

module uart_tx #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_busy,
    output logic       txd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);

    logic [9:0]    sh;
    logic [3:0]    nbits;
    logic [CW-1:0] cnt;

    // Frame is {stop, data, start}; ones shift in behind it so the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '1;
            nbits <= '0;
            cnt   <= '0;
        end else if (nbits == 4'd0) begin
            if (TxD_start) begin
                sh    <= {1'b1, TxD_data, 1'b0};
                nbits <= 4'd10;
                cnt   <= '0;
            end
        end else if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            sh    <= {1'b1, sh[9:1]};
            nbits <= nbits - 4'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign txd      = sh[0];
    assign TxD_busy = (nbits != 4'd0);
endmodule

module uart_rx #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int CW   = $clog2(DIV + 1);
    // First sample lands mid start bit, allowing for the synchroniser and detect latency.
    localparam int HALF = (DIV / 2 > 3) ? DIV / 2 - 3 : 0;

    logic [1:0]    sync;
    logic          rx_s;
    logic          active;
    logic [3:0]    bitn;
    logic [CW-1:0] cnt;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync           <= 2'b11;
            active         <= 1'b0;
            bitn           <= '0;
            cnt            <= '0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
        end else begin
            sync           <= {sync[0], rxd};
            RxD_data_ready <= 1'b0;
            if (!active) begin
                if (!rx_s) begin
                    active <= 1'b1;
                    bitn   <= '0;
                    cnt    <= CW'(HALF);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= CW'(DIV - 1);
                if (bitn == 4'd0) begin
                    if (rx_s) active <= 1'b0;
                    else      bitn   <= 4'd1;
                end else if (bitn <= 4'd8) begin
                    RxD_data <= {rx_s, RxD_data[7:1]};
                    bitn     <= bitn + 4'd1;
                end else begin
                    active         <= 1'b0;
                    RxD_data_ready <= rx_s;
                end
            end
        end
    end
endmodule

// Command handshake: start is a one-cycle strobe accepted only while busy=0;
// mem_rdata must be valid exactly one clock after mem_addr is presented.
module uart_mem_xfer #(
    parameter int ADDR_W     = 16,
    parameter int WORD_BYTES = 1,
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int RX_TIMEOUT = 2500000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       first_addr,
    input  logic [ADDR_W-1:0]       last_addr,
    input  logic                    abort,
    input  logic                    rxd,
    output logic                    txd,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    input  logic [8*WORD_BYTES-1:0] mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W:0]         word_cnt,
    output logic [3:0]              dbg_state
);
    localparam int DW = 8 * WORD_BYTES;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, TX_RD, TX_LOAD, TX_BYTE, TX_WAIT, TX_NEXT, RX_BYTE, RX_WRITE, RX_NEXT, FINISH
    } state_t;

    state_t state, state_d;
    logic [ADDR_W-1:0] addr, addr_d, last_q, last_d;
    logic [1:0]        idx, idx_d;
    logic [DW-1:0]     tx_sh, tx_sh_d, rx_asm, rx_asm_d;
    logic [TW-1:0]     to_cnt, to_cnt_d;
    logic [ADDR_W:0]   word_cnt_d;
    logic              err_d, tx_start, tx_busy, rx_ready;
    logic [7:0]        rx_data;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk(clk), .rst_n(rst_n), .TxD_start(tx_start), .TxD_data(tx_sh[7:0]),
        .TxD_busy(tx_busy), .txd(txd)
    );

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .RxD_data_ready(rx_ready), .RxD_data(rx_data)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr;
        last_d     = last_q;
        idx_d      = idx;
        tx_sh_d    = tx_sh;
        rx_asm_d   = rx_asm;
        to_cnt_d   = '0;
        word_cnt_d = word_cnt;
        err_d      = err;
        tx_start   = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (first_addr > last_addr) begin
                    err_d = 1'b1;
                end else begin
                    addr_d     = first_addr;
                    last_d     = last_addr;
                    idx_d      = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = mode ? TX_RD : RX_BYTE;
                end
            end
            TX_RD:   state_d = TX_LOAD;
            TX_LOAD: begin
                tx_sh_d = mem_rdata;
                idx_d   = '0;
                state_d = TX_BYTE;
            end
            TX_BYTE: begin
                tx_start = 1'b1;
                state_d  = TX_WAIT;
            end
            TX_WAIT: if (!tx_busy) begin
                if (idx != LAST_IDX) begin
                    idx_d   = idx + 2'd1;
                    tx_sh_d = tx_sh >> 8;
                    state_d = TX_BYTE;
                end else begin
                    state_d = TX_NEXT;
                end
            end
            TX_NEXT: begin
                word_cnt_d = word_cnt + 1'b1;
                if (addr == last_q) state_d = FINISH;
                else begin
                    addr_d  = addr + 1'b1;
                    state_d = TX_RD;
                end
            end
            RX_BYTE: if (rx_ready) begin
                for (int b = 0; b < WORD_BYTES; b++)
                    if (idx == 2'(b)) rx_asm_d[8*b +: 8] = rx_data;
                if (idx == LAST_IDX) state_d = RX_WRITE;
                else                 idx_d   = idx + 2'd1;
            end else if (to_cnt == TW'(RX_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = FINISH;
            end else begin
                to_cnt_d = to_cnt + 1'b1;
            end
            RX_WRITE: state_d = RX_NEXT;
            RX_NEXT: begin
                word_cnt_d = word_cnt + 1'b1;
                idx_d      = '0;
                if (addr == last_q) state_d = FINISH;
                else begin
                    addr_d  = addr + 1'b1;
                    state_d = RX_BYTE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // FINISH is already the exit path, so abort only redirects live transfer states.
        if (abort && state != IDLE && state != FINISH) begin
            state_d  = FINISH;
            err_d    = 1'b1;
            tx_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            last_q    <= '0;
            idx       <= '0;
            tx_sh     <= '0;
            rx_asm    <= '0;
            to_cnt    <= '0;
            word_cnt  <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            addr     <= addr_d;
            last_q   <= last_d;
            idx      <= idx_d;
            tx_sh    <= tx_sh_d;
            rx_asm   <= rx_asm_d;
            to_cnt   <= to_cnt_d;
            word_cnt <= word_cnt_d;
            err      <= err_d;
            mem_we   <= (state_d == RX_WRITE);
            busy     <= (state_d != IDLE);
            done     <= (state_d == FINISH) && !err_d;
            if (state_d == TX_RD || state_d == RX_WRITE) mem_addr <= addr_d;
            if (state_d == RX_WRITE) mem_wdata <= rx_asm_d;
        end
    end
endmodule

// File: doc/uart_mem_xfer.md
UART_MEM_XFER -- requirements
Module: uart_mem_xfer

Interface
REQ-001 Parameter ADDR_W, default 16: memory address width, 8..24.
REQ-002 Parameter WORD_BYTES, default 1: bytes per memory word, 1..4; word width DW = 8*WORD_BYTES.
REQ-003 Parameter CLK_FREQ, default 25000000, and BAUD, default 115200: passed unchanged to the uart_tx and uart_rx cores.
REQ-004 Parameter RX_TIMEOUT, default 2500000: idle clocks allowed between received bytes before an abort.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-008 mode  input  1  transfer direction: 0 = receive (PC to memory), 1 = transmit (memory to PC); sampled with start.
REQ-009 first_addr, last_addr  input  ADDR_W each  inclusive address window; sampled with start.
REQ-010 abort  input  1  synchronous cancel request.
REQ-011 rxd  input  1  serial in.
REQ-012 txd  output  1  serial out.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wdata  output  DW  write data.
REQ-015 mem_we  output  1  one-cycle write strobe.
REQ-016 mem_rdata  input  DW  read data, valid exactly 1 clock after mem_addr is presented.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on successful completion.
REQ-019 err  output  1  sticky error flag: timeout, abort or bad window; cleared by the next accepted start.
REQ-020 word_cnt  output  ADDR_W+1  number of words completed in the current or last transfer.

Function
REQ-021 States: IDLE, TX_RD, TX_LOAD, TX_BYTE, TX_WAIT, TX_NEXT, RX_BYTE, RX_WRITE, RX_NEXT, FINISH.
REQ-022 IDLE, start=1, first_addr>last_addr: no transfer starts; err=1 next cycle; stay in IDLE.
REQ-023 IDLE, start=1, valid window: latch the window, set addr=first_addr, word_cnt=0, err=0; go to TX_RD (mode=1) or RX_BYTE (mode=0).
REQ-024 TX_RD: drive mem_addr=addr; next state TX_LOAD.
REQ-025 TX_LOAD: capture mem_rdata into the shift register; byte index=0; go to TX_BYTE.
REQ-026 TX_BYTE: assert TxD_start for exactly one cycle with the current byte, least-significant byte first; go to TX_WAIT.
REQ-027 TX_WAIT: stay until TxD_busy=0, with a minimum of 1 cycle after TX_BYTE.
REQ-028 On leaving TX_WAIT: if byte index<WORD_BYTES-1, increment the index and go to TX_BYTE; otherwise go to TX_NEXT.
REQ-029 TX_NEXT: word_cnt+1; if addr==last_addr go to FINISH, else addr+1 and go to TX_RD.
REQ-030 RX_BYTE: on RxD_data_ready, place RxD_data into byte lane [index] of the assembly register.
REQ-031 RX_BYTE after a captured byte: if index==WORD_BYTES-1 go to RX_WRITE, otherwise increment the index.
REQ-032 RX_BYTE: the timeout counter resets on every received byte.
REQ-033 RX_WRITE: drive mem_addr=addr, mem_wdata=assembled word, mem_we=1 for one cycle; go to RX_NEXT.
REQ-034 RX_NEXT: word_cnt+1 and index=0; if addr==last_addr go to FINISH, else addr+1 and go to RX_BYTE.
REQ-035 Timeout: RX_TIMEOUT consecutive clocks in RX_BYTE without a byte sets err=1 and goes to FINISH. A partially assembled word is discarded (no write).
REQ-036 abort=1 in any non-IDLE state: set err=1 and go to FINISH next cycle. A byte already in flight on txd completes inside the uart_tx core, and no further TxD_start is issued.
REQ-037 FINISH: done=1 for one cycle if err=0, done=0 if err=1; go to IDLE.
REQ-038 Address arithmetic is ADDR_W bits. last_addr = 2^ADDR_W-1 terminates on the equality compare with no wrap.
REQ-039 start while busy is ignored. A byte received in IDLE or during transmit is dropped.
REQ-040 mem_we is 0 and mem_addr holds its last value in every state except the one driving it.
REQ-041 All outputs are registered except txd, which comes straight from uart_tx.

Reset
REQ-042 rst_n=0 immediately forces: IDLE, busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, word_cnt=0, TxD_start=0, txd=1 (idle line).
REQ-043 Reset mid-transfer abandons the transfer with no further mem_we and no done pulse. Operation resumes on the first clk edge after rst_n rises.

Verification
REQ-044 WORD_BYTES=1; mode=0, window 0..3; send 0x11,0x22,0x33,0x44 -> four mem_we at addr 0..3 with matching data, then done pulse, word_cnt=4.
REQ-045 WORD_BYTES=2; mode=1, window 5..6; mem holds [5]=0xBEEF and [6]=0x1234 -> txd bytes EF,BE,34,12 in that order, then done, word_cnt=2.
REQ-046 mode=0, window 0..9, RX_TIMEOUT=1000; send 3 bytes then stop -> 3 writes, err=1, no done pulse, busy=0 within 1002 clocks of the last byte.
REQ-047 start with first_addr=8, last_addr=7 -> err=1, busy stays 0, no memory access.
REQ-048 ADDR_W=8; window 0xFE..0xFF receive -> exactly two writes, ending at 0xFF, no wrap to 0x00, done.
REQ-049 Assert rst_n=0 during the 2nd word of a transmit -> outputs take reset values immediately, txd=1. A subsequent start then runs normally.
